prog_ctr_ras: RTL and testbench
===============================

PROG_CTR_RAS -- requirements
Module: prog_ctr_ras

Interface
REQ-001 The block SHALL have parameter PC_W, default 10, program counter width in bits.
REQ-002 The block SHALL have parameter RAS_DEPTH, default 4, return-address stack entries (power of two, >=2).
REQ-003 The block SHALL have port Clk  input  1  clock; all state changes on posedge only.
REQ-004 The block SHALL have port Reset  input  1  reset Reset, synchronous, active-high.
REQ-005 The block SHALL have port Start  input  1  load StartAddr and hold while high; run on release.
REQ-006 The block SHALL have port StartAddr  input  PC_W  entry address of the selected program.
REQ-007 The block SHALL have port Stall  input  1  freeze PC and stack this cycle.
REQ-008 The block SHALL have port BrOp  input  3  0=NEXT, 1=JMP abs, 2=BRC rel cond, 3=CALL, 4=RET, 5=HALT, 6/7=NEXT.
REQ-009 The block SHALL have port Flag  input  1  ALU condition for BRC.
REQ-010 The block SHALL have port Target  input  PC_W  absolute address (JMP/CALL) or signed two's-complement offset (BRC).
REQ-011 The block SHALL have port ProgCtr  output  PC_W  program counter register.
REQ-012 The block SHALL have port Done  output  1  high while halted.
REQ-013 The block SHALL have port RasDepth  output  $clog2(RAS_DEPTH)+1  valid stack entries.
REQ-014 The block SHALL have ports RasOvf, RasUnf  output  1 each  sticky overflow / underflow flags.

Function
REQ-015 Per-cycle priority SHALL be: Reset > Start > Done (halted) > Stall > BrOp.
REQ-016 Start high SHALL load ProgCtr<=StartAddr every cycle, clear Done, RasDepth, RasOvf, RasUnf; first fetch is StartAddr on the cycle after Start falls.
REQ-017 While Done=1 and Start=0, ProgCtr, stack and flags SHALL hold regardless of Stall/BrOp.
REQ-018 Stall=1 SHALL hold ProgCtr and stack; BrOp ignored that cycle, no push/pop.
REQ-019 NEXT: ProgCtr<=ProgCtr+1.
REQ-020 JMP: ProgCtr<=Target.
REQ-021 BRC: if Flag, ProgCtr<=ProgCtr+sign-extended Target; else ProgCtr+1.
REQ-022 CALL: push ProgCtr+1, ProgCtr<=Target, RasDepth+1.
REQ-023 CALL with RasDepth=RAS_DEPTH SHALL overwrite oldest entry (circular), keep RasDepth=RAS_DEPTH, set RasOvf.
REQ-024 RET with RasDepth>0: ProgCtr<=top entry, RasDepth-1.
REQ-025 RET with RasDepth=0 SHALL set RasUnf and ProgCtr<=ProgCtr+1; stack pointer unchanged.
REQ-026 HALT: ProgCtr holds, Done<=1 next cycle.
REQ-027 All PC arithmetic SHALL wrap modulo 2^PC_W; no flag on wrap.
REQ-028 RasOvf/RasUnf SHALL remain set until Reset or Start.
REQ-029 Latency: every update visible on ProgCtr one cycle after the qualifying edge; outputs are registers, no combinational input-to-output path.

Reset
REQ-030 Reset=1 SHALL set ProgCtr=0, Done=0, RasDepth=0, RasOvf=0, RasUnf=0 at next posedge, overriding Start, Stall, BrOp.
REQ-031 Reset mid-CALL/RET SHALL discard the stack operation; stack contents need not be cleared but are unreachable (RasDepth=0).

Verification
REQ-032 Reset, Start=1 StartAddr=0x100 for 3 cycles, release, 4x NEXT -> ProgCtr 0x100,0x101,0x102,0x103,0x104.
REQ-033 At PC=0x020 BRC Target=0x3FA (-6) Flag=1 -> 0x01A; same with Flag=0 -> 0x021; at 0x3FF NEXT -> 0x000.
REQ-034 At PC=0x010 CALL 0x200, then NEXT, RET -> 0x200,0x201,0x011; RasDepth 1 then 0.
REQ-035 Five nested CALLs (RAS_DEPTH=4) then five RETs -> RasOvf=1 after 5th CALL, 4 correct returns, 5th RET sets RasUnf and increments PC.
REQ-036 Stall=1 with BrOp=CALL for 2 cycles -> ProgCtr and RasDepth unchanged; HALT -> Done=1, PC frozen until Start.
REQ-037 Reset asserted same cycle as Start=1 and BrOp=JMP -> ProgCtr=0, all flags 0.

Source files
------------

// File: rtl/prog_ctr_ras.sv
// Program counter with relative/absolute branching and a circular return-address stack.
// All outputs are registers; the stack keeps its oldest entries overwritable on overflow.
module prog_ctr_ras #(
    parameter int PC_W      = 10,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Start,
    input  logic [PC_W-1:0]              StartAddr,
    input  logic                         Stall,
    input  logic [2:0]                   BrOp,
    input  logic                         Flag,
    input  logic [PC_W-1:0]              Target,
    output logic [PC_W-1:0]              ProgCtr,
    output logic                         Done,
    output logic [$clog2(RAS_DEPTH):0]   RasDepth,
    output logic                         RasOvf,
    output logic                         RasUnf
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int DEP_W = PTR_W + 1;

    typedef enum logic [2:0] {
        OP_NEXT = 3'd0,
        OP_JMP  = 3'd1,
        OP_BRC  = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_HALT = 3'd5
    } brop_e;

    logic [RAS_DEPTH-1:0][PC_W-1:0] ras;
    logic [PTR_W-1:0]               ptr, ptr_nxt, ptr_m1;
    logic [PC_W-1:0]                pc_nxt, pc_inc;
    logic [DEP_W-1:0]               depth_nxt;
    logic                           done_nxt, ovf_nxt, unf_nxt, push;
    logic                           full;

    // ptr names the slot the next push writes; the top entry sits just below it
    assign pc_inc = ProgCtr + PC_W'(1);
    assign ptr_m1 = ptr - PTR_W'(1);
    assign full   = (RasDepth == DEP_W'(RAS_DEPTH));

    always_comb begin
        pc_nxt    = ProgCtr;
        done_nxt  = Done;
        depth_nxt = RasDepth;
        ptr_nxt   = ptr;
        ovf_nxt   = RasOvf;
        unf_nxt   = RasUnf;
        push      = 1'b0;
        if (Reset) begin
            pc_nxt    = '0;
            done_nxt  = 1'b0;
            depth_nxt = '0;
            ptr_nxt   = '0;
            ovf_nxt   = 1'b0;
            unf_nxt   = 1'b0;
        end else if (Start) begin
            pc_nxt    = StartAddr;
            done_nxt  = 1'b0;
            depth_nxt = '0;
            ovf_nxt   = 1'b0;
            unf_nxt   = 1'b0;
        end else if (!Done && !Stall) begin
            case (brop_e'(BrOp))
                OP_JMP:  pc_nxt = Target;
                OP_BRC:  pc_nxt = Flag ? ProgCtr + Target : pc_inc;
                OP_CALL: begin
                    push    = 1'b1;
                    pc_nxt  = Target;
                    ptr_nxt = ptr + PTR_W'(1);
                    if (full) ovf_nxt = 1'b1;
                    else      depth_nxt = RasDepth + DEP_W'(1);
                end
                OP_RET: begin
                    if (RasDepth != '0) begin
                        pc_nxt    = ras[ptr_m1];
                        ptr_nxt   = ptr_m1;
                        depth_nxt = RasDepth - DEP_W'(1);
                    end else begin
                        pc_nxt  = pc_inc;
                        unf_nxt = 1'b1;
                    end
                end
                OP_HALT: done_nxt = 1'b1;
                default: pc_nxt = pc_inc;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        ProgCtr  <= pc_nxt;
        Done     <= done_nxt;
        RasDepth <= depth_nxt;
        ptr      <= ptr_nxt;
        RasOvf   <= ovf_nxt;
        RasUnf   <= unf_nxt;
        if (push) ras[ptr] <= pc_inc;
    end
endmodule

// File: tb/tb_prog_ctr_ras.sv
// Bench for prog_ctr_ras: queue-based reference model checked every cycle, plus directed literals.
module tb_prog_ctr_ras;
    localparam int PC_W = 10;
    localparam int RAS_DEPTH = 4;
    localparam int PCM = (1 << PC_W) - 1;

    logic            Clk = 0;
    logic            Reset, Start, Stall, Flag;
    logic [PC_W-1:0] StartAddr, Target;
    logic [2:0]      BrOp;
    logic [PC_W-1:0] ProgCtr;
    logic            Done, RasOvf, RasUnf;
    logic [2:0]      RasDepth;

    int total = 0;
    int bad = 0;
    bit chk_en = 0;

    int m_pc, m_done, m_ovf, m_unf;
    int q[$];

    prog_ctr_ras #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr), .Stall(Stall),
        .BrOp(BrOp), .Flag(Flag), .Target(Target), .ProgCtr(ProgCtr), .Done(Done),
        .RasDepth(RasDepth), .RasOvf(RasOvf), .RasUnf(RasUnf)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: return addresses kept as a plain queue, oldest dropped on overflow
    always @(posedge Clk) begin
        if (Reset) begin
            m_pc = 0; m_done = 0; m_ovf = 0; m_unf = 0; q.delete();
        end else if (Start) begin
            m_pc = int'(StartAddr); m_done = 0; m_ovf = 0; m_unf = 0; q.delete();
        end else if (m_done == 0 && !Stall) begin
            case (BrOp)
                3'd1: m_pc = int'(Target);
                3'd2: m_pc = Flag ? (m_pc + int'(Target)) & PCM : (m_pc + 1) & PCM;
                3'd3: begin
                    q.push_back((m_pc + 1) & PCM);
                    if (q.size() > RAS_DEPTH) begin
                        void'(q.pop_front());
                        m_ovf = 1;
                    end
                    m_pc = int'(Target);
                end
                3'd4: begin
                    if (q.size() > 0) m_pc = q.pop_back();
                    else begin m_unf = 1; m_pc = (m_pc + 1) & PCM; end
                end
                3'd5: m_done = 1;
                default: m_pc = (m_pc + 1) & PCM;
            endcase
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("model_pc", 32'(ProgCtr), 32'(m_pc));
            chk("model_done", 32'(Done), 32'(m_done));
            chk("model_depth", 32'(RasDepth), 32'(q.size()));
            chk("model_ovf", 32'(RasOvf), 32'(m_ovf));
            chk("model_unf", 32'(RasUnf), 32'(m_unf));
        end
    end

    task automatic go(input logic [2:0] op, input logic [PC_W-1:0] tgt, input logic fl);
        BrOp = op; Target = tgt; Flag = fl;
        @(posedge Clk); #1;
    endtask

    initial begin
        Reset = 1; Start = 0; Stall = 0; BrOp = 0; Flag = 0; Target = 0; StartAddr = 0;
        go(0, 0, 0); go(0, 0, 0);
        chk("rst_pc", 32'(ProgCtr), 0);
        chk("rst_flags", {Done, RasOvf, RasUnf}, 0);
        chk("rst_depth", 32'(RasDepth), 0);
        chk_en = 1;

        // Start hold and release
        Reset = 0; Start = 1; StartAddr = 10'h100;
        for (int i = 0; i < 3; i++) begin
            go(0, 0, 0);
            chk("start_hold", 32'(ProgCtr), 32'h100);
        end
        Start = 0;
        for (int i = 1; i <= 4; i++) begin
            go(0, 0, 0);
            chk("next_seq", 32'(ProgCtr), 32'h100 + i);
        end

        // Relative branch and wrap
        go(1, 10'h020, 0); chk("jmp", 32'(ProgCtr), 32'h020);
        go(2, 10'h3FA, 1); chk("brc_taken", 32'(ProgCtr), 32'h01A);
        go(1, 10'h020, 0);
        go(2, 10'h3FA, 0); chk("brc_not", 32'(ProgCtr), 32'h021);
        go(1, 10'h3FF, 0);
        go(0, 0, 0);       chk("wrap", 32'(ProgCtr), 32'h000);

        // Single call/return
        go(1, 10'h010, 0);
        go(3, 10'h200, 0); chk("call_pc", 32'(ProgCtr), 32'h200); chk("call_dep", 32'(RasDepth), 1);
        go(0, 0, 0);       chk("call_next", 32'(ProgCtr), 32'h201);
        go(4, 0, 0);       chk("ret_pc", 32'(ProgCtr), 32'h011); chk("ret_dep", 32'(RasDepth), 0);

        // Five nested calls overflow a 4-deep stack
        go(1, 10'h040, 0);
        go(3, 10'h080, 0); go(3, 10'h0C0, 0); go(3, 10'h100, 0); go(3, 10'h140, 0);
        chk("ovf_before", 32'(RasOvf), 0);
        go(3, 10'h180, 0);
        chk("ovf_after", 32'(RasOvf), 1); chk("ovf_dep", 32'(RasDepth), 4);
        go(4, 0, 0); chk("ret1", 32'(ProgCtr), 32'h141);
        go(4, 0, 0); chk("ret2", 32'(ProgCtr), 32'h101);
        go(4, 0, 0); chk("ret3", 32'(ProgCtr), 32'h0C1);
        go(4, 0, 0); chk("ret4", 32'(ProgCtr), 32'h081);
        chk("unf_before", 32'(RasUnf), 0);
        go(4, 0, 0); chk("ret5_pc", 32'(ProgCtr), 32'h082); chk("ret5_unf", 32'(RasUnf), 1);

        // Stall suppresses a call; halt freezes until Start
        go(3, 10'h300, 0);
        Stall = 1;
        go(3, 10'h111, 0); go(3, 10'h111, 0);
        chk("stall_pc", 32'(ProgCtr), 32'h300); chk("stall_dep", 32'(RasDepth), 1);
        Stall = 0;
        go(5, 0, 0); chk("halt_done", 32'(Done), 1); chk("halt_pc", 32'(ProgCtr), 32'h300);
        go(1, 10'h055, 0); Stall = 1; go(4, 0, 0); Stall = 0; go(3, 10'h066, 0);
        chk("halt_frozen", 32'(ProgCtr), 32'h300); chk("halt_dep", 32'(RasDepth), 1);
        Start = 1; StartAddr = 10'h0AA;
        go(1, 10'h055, 0);
        chk("restart_pc", 32'(ProgCtr), 32'h0AA);
        chk("restart_flags", {Done, RasOvf, RasUnf}, 0); chk("restart_dep", 32'(RasDepth), 0);
        Start = 0;

        // Reset beats Start and JMP
        go(4, 0, 0); chk("unf_again", 32'(RasUnf), 1); chk("unf_pc", 32'(ProgCtr), 32'h0AB);
        go(3, 10'h0F0, 0);
        Reset = 1; Start = 1; StartAddr = 10'h1AB;
        go(1, 10'h123, 0);
        chk("rst_prio_pc", 32'(ProgCtr), 0);
        chk("rst_prio_flags", {Done, RasOvf, RasUnf}, 0); chk("rst_prio_dep", 32'(RasDepth), 0);
        Reset = 0; Start = 0;

        // Mixed traffic, checked only against the model
        for (int i = 0; i < 60; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            if (op == 3'd5) op = 3'd3;
            Stall = ($urandom_range(0, 5) == 0);
            go(op, 10'($urandom), 1'($urandom));
        end
        Stall = 0;
        go(0, 0, 0);

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
